// File: rtl/xadac_exe_arb.sv
`default_nettype none
// =============================================================================
// Module   : xadac_exe_arb
// Purpose  : Round-robin arbiter sharing one execute unit among NumSlv ports;
//            responses return in request order via an order FIFO of grants.
//            Define XADAC_ARB_PERF_EN to add the stall_cnt output.
// Revision : 1.0
// =============================================================================
module xadac_exe_arb #(
    parameter int NumSlv = 2,
    parameter int ReqW   = 64,
    parameter int RspW   = 64,
    parameter int Depth  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NumSlv*ReqW-1:0]   slv_req_data,
    input  logic [NumSlv-1:0]        slv_req_valid,
    output logic [NumSlv-1:0]        slv_req_ready,
    output logic [RspW-1:0]          slv_rsp_data,
    output logic [NumSlv-1:0]        slv_rsp_valid,
    input  logic [NumSlv-1:0]        slv_rsp_ready,
    output logic [ReqW-1:0]          mst_req_data,
    output logic                     mst_req_valid,
    input  logic                     mst_req_ready,
    input  logic [RspW-1:0]          mst_rsp_data,
    input  logic                     mst_rsp_valid,
    output logic                     mst_rsp_ready,
    output logic                     err_orphan
`ifdef XADAC_ARB_PERF_EN
    ,
    output logic [31:0]              stall_cnt
`endif
);

    localparam int c_IDX_W = $clog2(NumSlv);
    localparam int c_PTR_W = $clog2(Depth);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_IDX_W:0]   c_NUM    = (c_IDX_W+1)'(NumSlv);
    localparam logic [c_CNT_W-1:0] c_DEPTH  = c_CNT_W'(Depth);
    localparam logic [c_IDX_W-1:0] c_RR_RST = c_IDX_W'(NumSlv - 1);

    logic [c_IDX_W-1:0] r_rr_ptr;
    logic               r_lock;
    logic [c_IDX_W-1:0] r_lock_idx;
    logic [c_IDX_W-1:0] r_fifo [Depth];
    logic [c_PTR_W-1:0] r_wr;
    logic [c_PTR_W-1:0] r_rd;
    logic [c_CNT_W-1:0] r_count;
    logic               r_err;

    logic [c_IDX_W-1:0] w_rr_idx;
    logic               w_rr_found;
    logic [c_IDX_W:0]   w_cand;
    logic [c_IDX_W-1:0] w_grant;
    logic               w_gnt_valid;
    logic               w_full;
    logic               w_empty;
    logic               w_req_hs;
    logic               w_rsp_hs;
    logic [c_IDX_W-1:0] w_head;

    // First valid port strictly after the last granted one, wrapping.
    always_comb begin
        w_rr_idx   = r_rr_ptr;
        w_rr_found = 1'b0;
        w_cand     = '0;
        for (int k = 1; k <= NumSlv; k++) begin
            w_cand = (c_IDX_W+1)'(r_rr_ptr) + (c_IDX_W+1)'(k);
            if (w_cand >= c_NUM) begin
                w_cand = w_cand - c_NUM;
            end
            if (!w_rr_found && slv_req_valid[w_cand[c_IDX_W-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand[c_IDX_W-1:0];
            end
        end
    end

    assign w_grant     = r_lock ? r_lock_idx : w_rr_idx;
    assign w_gnt_valid = slv_req_valid[w_grant];
    assign w_full      = (r_count == c_DEPTH);
    assign w_empty     = (r_count == '0);

    assign mst_req_valid = !rst && !w_full && w_gnt_valid;
    assign mst_req_data  = slv_req_data[w_grant*ReqW +: ReqW];
    assign w_req_hs      = mst_req_valid && mst_req_ready;

    always_comb begin
        slv_req_ready = '0;
        if (!rst && !w_full) begin
            slv_req_ready[w_grant] = mst_req_ready;
        end
    end

    assign w_head = r_fifo[r_rd];

    // With nothing outstanding, responses are orphans: accept and drop them.
    always_comb begin
        slv_rsp_valid = '0;
        if (!rst && !w_empty) begin
            slv_rsp_valid[w_head] = mst_rsp_valid;
        end
    end

    assign mst_rsp_ready = rst ? 1'b0 : (w_empty ? 1'b1 : slv_rsp_ready[w_head]);
    assign slv_rsp_data  = mst_rsp_data;
    assign w_rsp_hs      = !rst && !w_empty && mst_rsp_valid && mst_rsp_ready;
    assign err_orphan    = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= c_RR_RST;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_req_hs) begin
                r_wr     <= r_wr + 1'b1;
                r_rr_ptr <= w_grant;
                r_lock   <= 1'b0;
            end else if (mst_req_valid) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_grant;
            end
            if (w_rsp_hs) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_req_hs, w_rsp_hs})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_empty && mst_rsp_valid) begin
                r_err <= 1'b1;
            end
        end
    end

    // Order storage needs no reset; only entries between rd and wr are read.
    always_ff @(posedge clk) begin
        if (!rst && w_req_hs) begin
            r_fifo[r_wr] <= w_grant;
        end
    end

`ifdef XADAC_ARB_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (|slv_req_valid && !w_req_hs && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xadac_exe_arb.sv
`default_nettype none
// =============================================================================
// Module   : tb_xadac_exe_arb
// Purpose  : Directed self-checking bench for xadac_exe_arb (NumSlv=2, Depth=4).
// Revision : 1.0
// =============================================================================
module tb_xadac_exe_arb;

    localparam int NUM_SLV = 2;
    localparam int REQ_W   = 16;
    localparam int RSP_W   = 16;
    localparam int DEPTH   = 4;

    localparam logic [REQ_W-1:0] P0 = 16'h1000;
    localparam logic [REQ_W-1:0] P1 = 16'h2001;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_SLV*REQ_W-1:0]   slv_req_data;
    logic [NUM_SLV-1:0]         slv_req_valid;
    logic [NUM_SLV-1:0]         slv_req_ready;
    logic [RSP_W-1:0]           slv_rsp_data;
    logic [NUM_SLV-1:0]         slv_rsp_valid;
    logic [NUM_SLV-1:0]         slv_rsp_ready;
    logic [REQ_W-1:0]           mst_req_data;
    logic                       mst_req_valid;
    logic                       mst_req_ready;
    logic [RSP_W-1:0]           mst_rsp_data;
    logic                       mst_rsp_valid;
    logic                       mst_rsp_ready;
    logic                       err_orphan;
`ifdef XADAC_ARB_PERF_EN
    logic [31:0]                stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    xadac_exe_arb #(
        .NumSlv (NUM_SLV),
        .ReqW   (REQ_W),
        .RspW   (RSP_W),
        .Depth  (DEPTH)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .slv_req_data  (slv_req_data),
        .slv_req_valid (slv_req_valid),
        .slv_req_ready (slv_req_ready),
        .slv_rsp_data  (slv_rsp_data),
        .slv_rsp_valid (slv_rsp_valid),
        .slv_rsp_ready (slv_rsp_ready),
        .mst_req_data  (mst_req_data),
        .mst_req_valid (mst_req_valid),
        .mst_req_ready (mst_req_ready),
        .mst_rsp_data  (mst_rsp_data),
        .mst_rsp_valid (mst_rsp_valid),
        .mst_rsp_ready (mst_rsp_ready),
        .err_orphan    (err_orphan)
`ifdef XADAC_ARB_PERF_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        slv_req_data  = {P1, P0};
        slv_req_valid = 2'b11;
        slv_rsp_ready = 2'b11;
        mst_req_ready = 1'b1;
        mst_rsp_data  = '0;
        mst_rsp_valid = 1'b1;
        tick();
        tick();
        settle();
        chk("rst_mst_req_valid", 64'(mst_req_valid), 64'd0);
        chk("rst_slv_req_ready", 64'(slv_req_ready), 64'd0);
        chk("rst_slv_rsp_valid", 64'(slv_rsp_valid), 64'd0);
        chk("rst_mst_rsp_ready", 64'(mst_rsp_ready), 64'd0);
        chk("rst_err_orphan",    64'(err_orphan),    64'd0);

        // Round-robin alternation from reset; port 0 first.
        tick();
        rst           = 1'b0;
        mst_rsp_valid = 1'b0;
        settle();
        chk("rr0_data",  64'(mst_req_data),  64'(P0));
        chk("rr0_ready", 64'(slv_req_ready), 64'd1);
        chk("rr0_valid", 64'(mst_req_valid), 64'd1);
        tick(); settle();
        chk("rr1_data",  64'(mst_req_data),  64'(P1));
        chk("rr1_ready", 64'(slv_req_ready), 64'd2);
        tick(); settle();
        chk("rr2_data",  64'(mst_req_data),  64'(P0));
        chk("rr2_ready", 64'(slv_req_ready), 64'd1);
        tick(); settle();
        chk("rr3_data",  64'(mst_req_data),  64'(P1));
        chk("rr3_ready", 64'(slv_req_ready), 64'd2);

        // FIFO holds 0,1,0,1: full blocks the 5th request.
        tick(); settle();
        chk("full_mst_req_valid", 64'(mst_req_valid), 64'd0);
        chk("full_slv_req_ready", 64'(slv_req_ready), 64'd0);

        // Pop while full: slot is not freed in the same cycle.
        tick();
        mst_rsp_valid = 1'b1;
        mst_rsp_data  = 16'h000A;
        settle();
        chk("pop_full_rsp_valid", 64'(slv_rsp_valid), 64'd1);
        chk("pop_full_rsp_ready", 64'(mst_rsp_ready), 64'd1);
        chk("pop_full_rsp_data",  64'(slv_rsp_data),  64'h000A);
        chk("pop_full_req_valid", 64'(mst_req_valid), 64'd0);

        tick();
        mst_rsp_valid = 1'b0;
        settle();
        chk("after_pop_req_valid", 64'(mst_req_valid), 64'd1);
        chk("after_pop_req_ready", 64'(slv_req_ready), 64'd1);
        chk("after_pop_req_data",  64'(mst_req_data),  64'(P0));

        // FIFO now holds 1,0,1,0; port 1 initially stalls the response path.
        tick();
        slv_req_valid = 2'b00;
        mst_rsp_valid = 1'b1;
        mst_rsp_data  = 16'h000B;
        slv_rsp_ready = 2'b01;
        settle();
        chk("stall_rsp_valid", 64'(slv_rsp_valid), 64'd2);
        chk("stall_rsp_ready", 64'(mst_rsp_ready), 64'd0);
        tick();
        slv_rsp_ready = 2'b11;
        settle();
        chk("ord0_rsp_valid", 64'(slv_rsp_valid), 64'd2);
        chk("ord0_rsp_ready", 64'(mst_rsp_ready), 64'd1);
        chk("ord0_rsp_data",  64'(slv_rsp_data),  64'h000B);
        tick();
        mst_rsp_data = 16'h000C;
        settle();
        chk("ord1_rsp_valid", 64'(slv_rsp_valid), 64'd1);
        chk("ord1_rsp_data",  64'(slv_rsp_data),  64'h000C);
        tick();
        mst_rsp_data = 16'h000D;
        settle();
        chk("ord2_rsp_valid", 64'(slv_rsp_valid), 64'd2);
        tick();
        mst_rsp_data = 16'h000E;
        settle();
        chk("ord3_rsp_valid", 64'(slv_rsp_valid), 64'd1);
        tick();
        mst_rsp_valid = 1'b0;
        settle();
        chk("drained_err", 64'(err_orphan), 64'd0);

        // Port 1 alone moves the pointer to 1, so port 0 would win without a lock.
        slv_req_valid = 2'b10;
        settle();
        chk("p1_solo_ready", 64'(slv_req_ready), 64'd2);
        tick();
        mst_req_ready = 1'b0;
        settle();
        chk("lock_start_data", 64'(mst_req_data), 64'(P1));
        tick();
        slv_req_valid = 2'b11;
        settle();
        chk("lock_c1_data", 64'(mst_req_data), 64'(P1));
        tick(); settle();
        chk("lock_c2_data", 64'(mst_req_data), 64'(P1));
        tick(); settle();
        chk("lock_c3_data",  64'(mst_req_data),  64'(P1));
        chk("lock_c3_ready", 64'(slv_req_ready), 64'd0);
        tick();
        mst_req_ready = 1'b1;
        settle();
        chk("lock_hs_data",  64'(mst_req_data),  64'(P1));
        chk("lock_hs_ready", 64'(slv_req_ready), 64'd2);
        tick(); settle();
        chk("post_lock_data",  64'(mst_req_data),  64'(P0));
        chk("post_lock_ready", 64'(slv_req_ready), 64'd1);

        // Reset with entries outstanding: the next response is an orphan.
        tick();
        slv_req_valid = 2'b00;
        rst           = 1'b1;
        tick();
        rst           = 1'b0;
        mst_rsp_valid = 1'b1;
        mst_rsp_data  = 16'h0055;
        settle();
        chk("orph_rsp_valid", 64'(slv_rsp_valid), 64'd0);
        chk("orph_rsp_ready", 64'(mst_rsp_ready), 64'd1);
        chk("orph_err_pre",   64'(err_orphan),    64'd0);
        tick();
        mst_rsp_valid = 1'b0;
        settle();
        chk("orph_err_set", 64'(err_orphan), 64'd1);
        tick(); tick(); settle();
        chk("orph_err_sticky", 64'(err_orphan), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("orph_err_cleared", 64'(err_orphan), 64'd0);

`ifdef XADAC_ARB_PERF_EN
        chk("stall_cnt_reset", 64'(stall_cnt), 64'd0);
        mst_req_ready = 1'b0;
        slv_req_valid = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        slv_req_valid = 2'b00;
        settle();
        chk("stall_cnt_5", 64'(stall_cnt), 64'd5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
